// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: single-port RAM arbiter between the icache and dcache.
// One word per grant; every completion returns to IDLE before the next grant.
// Build option: define ARB_RR_EN for round-robin arbitration between the two
// caches; left undefined, the dcache always wins a contested IDLE cycle.
//
// Handshake: a cache raises its enable(s) with a stable address and holds
// them while its wait is 1. Its wait is 0 for exactly one cycle, the cycle
// the granted RAM access returns ACCESS, and load data is valid only then.
// Dropping the enables before that cycle abandons the request.
//
// arb_state exposes the FSM state for observation: 0=IDLE, 1=GNT_I, 2=GNT_D.
module cache_mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic              iwait,
   output logic [DATA_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   output logic              dwait,
   output logic [DATA_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [DATA_W-1:0] ramstore,
   input  logic [DATA_W-1:0] ramload,
   input  logic [1:0]        ramstate,
   output logic [1:0]        arb_state
);

   localparam logic [1:0] RAM_ACCESS = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } state_t;

   state_t state;
   state_t next_state;
   logic   d_req;

   assign d_req     = dREN | dWEN;
   assign arb_state = state;

   // Load data is a straight pass-through; caches qualify it with their wait.
   assign iload = ramload;
   assign dload = ramload;

`ifdef ARB_RR_EN
   // 1 = the dcache wins the next contested IDLE cycle.
   logic rr_ptr;

   // Point at the other source after each completed word.
   always_ff @(posedge CLK) begin
      if (RST) begin
         rr_ptr <= 1'b0;
      end else if (!iwait) begin
         rr_ptr <= 1'b1;
      end else if (!dwait) begin
         rr_ptr <= 1'b0;
      end
   end
`endif

   // State register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Arbitration, RAM port drive, wait generation and next state.
   always_comb begin
      next_state = state;
      ramREN     = 1'b0;
      ramWEN     = 1'b0;
      ramaddr    = '0;
      ramstore   = '0;
      iwait      = 1'b1;
      dwait      = 1'b1;
      case (state)
         IDLE: begin
`ifdef ARB_RR_EN
            if (d_req && (!iREN || rr_ptr)) begin
               next_state = GNT_D;
            end else if (iREN) begin
               next_state = GNT_I;
            end
`else
            if (d_req) begin
               next_state = GNT_D;
            end else if (iREN) begin
               next_state = GNT_I;
            end
`endif
         end
         GNT_I: begin
            ramaddr = iaddr;
            if (!iREN) begin
               // Abandoned before ACCESS: release the RAM without completing.
               next_state = IDLE;
            end else begin
               ramREN = 1'b1;
               if (ramstate == RAM_ACCESS) begin
                  iwait      = 1'b0;
                  next_state = IDLE;
               end
            end
         end
         GNT_D: begin
            ramaddr  = daddr;
            ramstore = dstore;
            if (!d_req) begin
               next_state = IDLE;
            end else begin
               // A write takes precedence when both enables are high.
               if (dWEN) begin
                  ramWEN = 1'b1;
               end else begin
                  ramREN = 1'b1;
               end
               if (ramstate == RAM_ACCESS) begin
                  dwait      = 1'b0;
                  next_state = IDLE;
               end
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

endmodule
